// File: rtl/cpu_run_ctrl.sv
// Run-control sequencer for the single-cycle RV32I core: gates all commits through cpu_en
// and records why the core stopped (halt command, step, breakpoint, ebreak/ecall, timeout).
module cpu_run_ctrl #(
  parameter int XLEN       = 32,
  parameter int CNT_W      = 32,
  parameter int MAX_CYCLES = 2000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic             bp_en,
  input  logic [XLEN-1:0]  bp_addr,
  input  logic [XLEN-1:0]  pc,
  input  logic [XLEN-1:0]  instr,
  output logic             cpu_en,
  output logic             halted,
  output logic [2:0]       stop_cause,
  output logic             stop_pulse,
  output logic [CNT_W-1:0] instr_cnt
);

  typedef enum logic [1:0] {
    ST_HALT = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2
  } state_t;

  localparam logic [1:0] OP_RUN   = 2'b00;
  localparam logic [1:0] OP_HALT  = 2'b01;
  localparam logic [1:0] OP_STEP  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  localparam logic [2:0] CAUSE_NONE    = 3'd0;
  localparam logic [2:0] CAUSE_HALT    = 3'd1;
  localparam logic [2:0] CAUSE_STEP    = 3'd2;
  localparam logic [2:0] CAUSE_BP      = 3'd3;
  localparam logic [2:0] CAUSE_SYS     = 3'd4;
  localparam logic [2:0] CAUSE_TIMEOUT = 3'd5;

  localparam int              RUN_W     = $clog2(MAX_CYCLES + 1);
  localparam logic [RUN_W-1:0] RUN_LIMIT = RUN_W'(MAX_CYCLES);

  localparam logic [XLEN-1:0] INSTR_EBREAK = XLEN'(32'h0010_0073);
  localparam logic [XLEN-1:0] INSTR_ECALL  = XLEN'(32'h0000_0073);

  state_t           state;
  logic             skip;
  logic [RUN_W-1:0] run_cnt;

  logic       accept;
  logic       timeout_hit;
  logic       bp_hit;
  logic       sys_hit;
  logic       stop_hit;
  logic [2:0] hit_cause;

  assign cmd_ready = (state != ST_STEP);
  assign accept    = cmd_valid && cmd_ready;

  // Stop detection only matters in RUN; skip lets a resumed run step past the
  // breakpoint or ebreak it stopped on.
  always_comb begin
    timeout_hit = 1'b0;
    bp_hit      = 1'b0;
    sys_hit     = 1'b0;
    stop_hit    = 1'b0;
    hit_cause   = CAUSE_NONE;
    if (state == ST_RUN) begin
      timeout_hit = (run_cnt == RUN_LIMIT);
      bp_hit      = bp_en && (pc == bp_addr) && !skip;
      sys_hit     = ((instr == INSTR_EBREAK) || (instr == INSTR_ECALL)) && !skip;
      stop_hit    = timeout_hit || bp_hit || sys_hit;
      if (timeout_hit) begin
        hit_cause = CAUSE_TIMEOUT;
      end else if (bp_hit) begin
        hit_cause = CAUSE_BP;
      end else if (sys_hit) begin
        hit_cause = CAUSE_SYS;
      end
    end
  end

  // Reset masks the commit enable so a reset during RUN commits nothing.
  always_comb begin
    cpu_en = 1'b0;
    if (!reset) begin
      cpu_en = ((state == ST_RUN) && !stop_hit) || (state == ST_STEP);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_HALT;
      halted     <= 1'b1;
      stop_cause <= CAUSE_NONE;
      stop_pulse <= 1'b0;
      instr_cnt  <= '0;
      skip       <= 1'b0;
      run_cnt    <= '0;
    end else begin
      stop_pulse <= 1'b0;

      if (cpu_en) begin
        instr_cnt <= instr_cnt + 1'b1;
        skip      <= 1'b0;
      end

      case (state)
        ST_HALT: begin
          if (accept) begin
            case (cmd_op)
              OP_RUN: begin
                state      <= ST_RUN;
                halted     <= 1'b0;
                run_cnt    <= '0;
                skip       <= 1'b1;
                stop_cause <= CAUSE_NONE;
              end
              OP_STEP: begin
                state      <= ST_STEP;
                halted     <= 1'b0;
                stop_cause <= CAUSE_NONE;
              end
              OP_CLEAR: begin
                instr_cnt  <= '0;
                stop_cause <= CAUSE_NONE;
              end
              default: begin
              end
            endcase
          end
        end

        ST_RUN: begin
          if (cpu_en && (run_cnt != RUN_LIMIT)) begin
            run_cnt <= run_cnt + 1'b1;
          end
          // CLEAR overrides this cycle's count increment; a stop cause below still wins.
          if (accept && (cmd_op == OP_CLEAR)) begin
            instr_cnt  <= '0;
            stop_cause <= CAUSE_NONE;
          end
          if (stop_hit) begin
            state      <= ST_HALT;
            halted     <= 1'b1;
            stop_pulse <= 1'b1;
            stop_cause <= hit_cause;
          end else if (accept && (cmd_op == OP_HALT)) begin
            state      <= ST_HALT;
            halted     <= 1'b1;
            stop_pulse <= 1'b1;
            stop_cause <= CAUSE_HALT;
          end
        end

        ST_STEP: begin
          state      <= ST_HALT;
          halted     <= 1'b1;
          stop_pulse <= 1'b1;
          stop_cause <= CAUSE_STEP;
        end

        default: begin
          state  <= ST_HALT;
          halted <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed self-checking bench for cpu_run_ctrl with a tiny PC/instruction-memory model.
module tb_cpu_run_ctrl;

  localparam int XLEN  = 32;
  localparam int CNT_W = 32;
  localparam int MAXC  = 20;

  localparam logic [1:0] OP_RUN   = 2'b00;
  localparam logic [1:0] OP_HALT  = 2'b01;
  localparam logic [1:0] OP_STEP  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] EBREAK   = 32'h0010_0073;
  localparam logic [31:0] JAL_SELF = 32'h0000_006f;

  logic             clk = 1'b0;
  logic             reset;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic             bp_en;
  logic [XLEN-1:0]  bp_addr;
  logic [XLEN-1:0]  pc;
  logic [XLEN-1:0]  instr;
  logic             cpu_en;
  logic             halted;
  logic [2:0]       stop_cause;
  logic             stop_pulse;
  logic [CNT_W-1:0] instr_cnt;

  logic [31:0]     imem [64];
  logic            pc_load;
  logic [XLEN-1:0] pc_load_val;

  int total = 0;
  int bad   = 0;

  cpu_run_ctrl #(.XLEN(XLEN), .CNT_W(CNT_W), .MAX_CYCLES(MAXC)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc), .instr(instr),
    .cpu_en(cpu_en), .halted(halted), .stop_cause(stop_cause),
    .stop_pulse(stop_pulse), .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  // Datapath stand-in: sequential PC, except a self-jump stays put.
  assign instr = imem[pc[7:2]];
  always @(posedge clk) begin
    if (reset) pc <= '0;
    else if (pc_load) pc <= pc_load_val;
    else if (cpu_en) pc <= (instr == JAL_SELF) ? pc : pc + 32'd4;
  end

  task automatic load_prog(input int ebreak_idx, input bit self_loop);
    for (int i = 0; i < 64; i++) imem[i] = NOP;
    if (ebreak_idx >= 0) imem[ebreak_idx] = EBREAK;
    if (self_loop) imem[0] = JAL_SELF;
  endtask

  task automatic set_pc(input logic [XLEN-1:0] v);
    @(negedge clk);
    pc_load = 1'b1; pc_load_val = v;
    @(negedge clk);
    pc_load = 1'b0;
  endtask

  task automatic send_cmd(input logic [1:0] op);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_halt(input int budget, output int en_cycles, output int pulses, output bit expired);
    en_cycles = 0; pulses = 0; expired = 1'b1;
    for (int i = 0; i < budget; i++) begin
      if (cpu_en) en_cycles++;
      if (stop_pulse) pulses++;
      if (halted) begin expired = 1'b0; break; end
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (halted !== 1'b1) begin bad++; $display("[TB] FAIL reset_halted got=%0b exp=1", halted); end
    total++; if (cpu_en !== 1'b0) begin bad++; $display("[TB] FAIL reset_cpu_en got=%0b exp=0", cpu_en); end
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_cmd_ready got=%0b exp=1", cmd_ready); end
    total++; if (stop_cause !== 3'd0) begin bad++; $display("[TB] FAIL reset_cause got=%0d exp=0", stop_cause); end
    total++; if (stop_pulse !== 1'b0) begin bad++; $display("[TB] FAIL reset_pulse got=%0b exp=0", stop_pulse); end
    total++; if (instr_cnt !== 32'd0) begin bad++; $display("[TB] FAIL reset_cnt got=%0d exp=0", instr_cnt); end
  endtask

  task automatic test_ebreak();
    int en; int pl; bit exp_to;
    load_prog(10, 1'b0);
    bp_en = 1'b0;
    send_cmd(OP_RUN);
    wait_halt(100, en, pl, exp_to);
    total++; if (exp_to) begin bad++; $display("[TB] FAIL ebreak_timeout got=expired exp=halt"); end
    total++; if (en !== 10) begin bad++; $display("[TB] FAIL ebreak_en_cycles got=%0d exp=10", en); end
    total++; if (pc !== 32'h28) begin bad++; $display("[TB] FAIL ebreak_pc got=%h exp=28", pc); end
    total++; if (stop_cause !== 3'd4) begin bad++; $display("[TB] FAIL ebreak_cause got=%0d exp=4", stop_cause); end
    total++; if (instr_cnt !== 32'd10) begin bad++; $display("[TB] FAIL ebreak_cnt got=%0d exp=10", instr_cnt); end
    total++; if (pl !== 1) begin bad++; $display("[TB] FAIL ebreak_pulses got=%0d exp=1", pl); end
    @(negedge clk);
    total++; if (stop_pulse !== 1'b0) begin bad++; $display("[TB] FAIL ebreak_pulse_width got=%0b exp=0", stop_pulse); end
  endtask

  task automatic test_breakpoint();
    int en; int pl; bit exp_to;
    load_prog(10, 1'b0);
    set_pc(32'h0);
    send_cmd(OP_CLEAR);
    bp_en = 1'b1; bp_addr = 32'h10;
    send_cmd(OP_RUN);
    wait_halt(100, en, pl, exp_to);
    total++; if (exp_to) begin bad++; $display("[TB] FAIL bp_timeout got=expired exp=halt"); end
    total++; if (pc !== 32'h10) begin bad++; $display("[TB] FAIL bp_pc got=%h exp=10", pc); end
    total++; if (instr_cnt !== 32'd4) begin bad++; $display("[TB] FAIL bp_cnt got=%0d exp=4", instr_cnt); end
    total++; if (stop_cause !== 3'd3) begin bad++; $display("[TB] FAIL bp_cause got=%0d exp=3", stop_cause); end
    send_cmd(OP_RUN);
    wait_halt(100, en, pl, exp_to);
    total++; if (exp_to) begin bad++; $display("[TB] FAIL bp_resume_timeout got=expired exp=halt"); end
    total++; if (pc !== 32'h28) begin bad++; $display("[TB] FAIL bp_resume_pc got=%h exp=28", pc); end
    total++; if (en !== 6) begin bad++; $display("[TB] FAIL bp_resume_en got=%0d exp=6", en); end
    total++; if (stop_cause !== 3'd4) begin bad++; $display("[TB] FAIL bp_resume_cause got=%0d exp=4", stop_cause); end
    bp_en = 1'b0;
  endtask

  task automatic test_step();
    load_prog(-1, 1'b0);
    set_pc(32'h0);
    send_cmd(OP_CLEAR);
    for (int s = 0; s < 3; s++) begin
      send_cmd(OP_STEP);
      total++; if (cpu_en !== 1'b1) begin bad++; $display("[TB] FAIL step_en got=%0b exp=1 step=%0d", cpu_en, s); end
      total++; if (cmd_ready !== 1'b0) begin bad++; $display("[TB] FAIL step_ready got=%0b exp=0 step=%0d", cmd_ready, s); end
      @(negedge clk);
      total++; if (cpu_en !== 1'b0) begin bad++; $display("[TB] FAIL step_en_after got=%0b exp=0 step=%0d", cpu_en, s); end
      total++; if (halted !== 1'b1 || stop_pulse !== 1'b1) begin bad++; $display("[TB] FAIL step_halt got=%0b/%0b exp=1/1 step=%0d", halted, stop_pulse, s); end
      total++; if (stop_cause !== 3'd2) begin bad++; $display("[TB] FAIL step_cause got=%0d exp=2 step=%0d", stop_cause, s); end
    end
    total++; if (instr_cnt !== 32'd3) begin bad++; $display("[TB] FAIL step_cnt got=%0d exp=3", instr_cnt); end
    total++; if (pc !== 32'd12) begin bad++; $display("[TB] FAIL step_pc got=%0d exp=12", pc); end
  endtask

  task automatic test_timeout();
    int en; int pl; bit exp_to;
    load_prog(-1, 1'b1);
    set_pc(32'h0);
    send_cmd(OP_CLEAR);
    send_cmd(OP_RUN);
    wait_halt(200, en, pl, exp_to);
    total++; if (exp_to) begin bad++; $display("[TB] FAIL timeout_wait got=expired exp=halt"); end
    total++; if (en !== 20) begin bad++; $display("[TB] FAIL timeout_en got=%0d exp=20", en); end
    total++; if (stop_cause !== 3'd5) begin bad++; $display("[TB] FAIL timeout_cause got=%0d exp=5", stop_cause); end
    total++; if (instr_cnt !== 32'd20) begin bad++; $display("[TB] FAIL timeout_cnt got=%0d exp=20", instr_cnt); end
  endtask

  task automatic test_halt_cmd();
    load_prog(10, 1'b0);
    set_pc(32'h0);
    send_cmd(OP_CLEAR);
    send_cmd(OP_RUN);
    repeat (4) @(negedge clk);
    total++; if (pc !== 32'h10 || cpu_en !== 1'b1) begin bad++; $display("[TB] FAIL halt_cycle5 got=%h/%0b exp=10/1", pc, cpu_en); end
    cmd_valid = 1'b1; cmd_op = OP_HALT;
    @(negedge clk);
    cmd_valid = 1'b0;
    total++; if (halted !== 1'b1 || stop_pulse !== 1'b1) begin bad++; $display("[TB] FAIL halt_state got=%0b/%0b exp=1/1", halted, stop_pulse); end
    total++; if (stop_cause !== 3'd1) begin bad++; $display("[TB] FAIL halt_cause got=%0d exp=1", stop_cause); end
    total++; if (instr_cnt !== 32'd5) begin bad++; $display("[TB] FAIL halt_cnt got=%0d exp=5", instr_cnt); end
    total++; if (pc !== 32'h14) begin bad++; $display("[TB] FAIL halt_pc got=%h exp=14", pc); end

    set_pc(32'h0);
    send_cmd(OP_CLEAR);
    bp_en = 1'b1; bp_addr = 32'h10;
    send_cmd(OP_RUN);
    repeat (4) @(negedge clk);
    total++; if (cpu_en !== 1'b0) begin bad++; $display("[TB] FAIL halt_bp_en got=%0b exp=0", cpu_en); end
    cmd_valid = 1'b1; cmd_op = OP_HALT;
    @(negedge clk);
    cmd_valid = 1'b0;
    total++; if (halted !== 1'b1) begin bad++; $display("[TB] FAIL halt_bp_halted got=%0b exp=1", halted); end
    total++; if (stop_cause !== 3'd3) begin bad++; $display("[TB] FAIL halt_bp_cause got=%0d exp=3", stop_cause); end
    total++; if (instr_cnt !== 32'd4 || pc !== 32'h10) begin bad++; $display("[TB] FAIL halt_bp_commit got=%0d/%h exp=4/10", instr_cnt, pc); end
    bp_en = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    load_prog(-1, 1'b0);
    set_pc(32'h0);
    send_cmd(OP_RUN);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    total++; if (cpu_en !== 1'b0) begin bad++; $display("[TB] FAIL rst_mid_en got=%0b exp=0", cpu_en); end
    @(negedge clk);
    total++; if (halted !== 1'b1 || instr_cnt !== 32'd0 || cpu_en !== 1'b0) begin bad++; $display("[TB] FAIL rst_mid_state got=%0b/%0d/%0b exp=1/0/0", halted, instr_cnt, cpu_en); end
    reset = 1'b0;
    @(negedge clk);
    total++; if (stop_pulse !== 1'b0 || stop_cause !== 3'd0 || cpu_en !== 1'b0) begin bad++; $display("[TB] FAIL rst_mid_after got=%0b/%0d/%0b exp=0/0/0", stop_pulse, stop_cause, cpu_en); end
  endtask

  task automatic test_clear_exec();
    int en; int pl; bit exp_to;
    load_prog(-1, 1'b0);
    set_pc(32'h0);
    send_cmd(OP_RUN);
    repeat (2) @(negedge clk);
    total++; if (cpu_en !== 1'b1 || instr_cnt !== 32'd2) begin bad++; $display("[TB] FAIL clr_pre got=%0b/%0d exp=1/2", cpu_en, instr_cnt); end
    cmd_valid = 1'b1; cmd_op = OP_CLEAR;
    @(negedge clk);
    cmd_valid = 1'b0;
    total++; if (instr_cnt !== 32'd0) begin bad++; $display("[TB] FAIL clr_exec_cnt got=%0d exp=0", instr_cnt); end
    total++; if (cpu_en !== 1'b1 || halted !== 1'b0) begin bad++; $display("[TB] FAIL clr_keeps_run got=%0b/%0b exp=1/0", cpu_en, halted); end
    @(negedge clk);
    total++; if (instr_cnt !== 32'd1) begin bad++; $display("[TB] FAIL clr_resume_cnt got=%0d exp=1", instr_cnt); end
    send_cmd(OP_HALT);
    wait_halt(10, en, pl, exp_to);
    total++; if (exp_to || stop_cause !== 3'd1) begin bad++; $display("[TB] FAIL clr_final_halt got=%0b/%0d exp=0/1", exp_to, stop_cause); end
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = OP_RUN;
    bp_en = 1'b0; bp_addr = '0; pc_load = 1'b0; pc_load_val = '0;
    load_prog(-1, 1'b0);
    test_reset();
    test_ebreak();
    test_breakpoint();
    test_step();
    test_timeout();
    test_halt_cmd();
    test_reset_mid_run();
    test_clear_exec();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
